// File: rtl/vt512_wb_ctrl.sv
// rtl/vt512_wb_ctrl.sv - VT512 Wishbone slave front-end, CSRs and target-bus sequencer
module vt512_wb_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [15:0] BASE_PAGE  = 16'h414E,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  tgt_valid_o,
  input  logic                  tgt_ready_i,
  output logic [1:0]            tgt_sel_o,
  output logic [5:0]            tgt_idx_o,
  output logic [DATA_WIDTH-1:0] tgt_data_o,
  output logic                  engine_start_o,
  input  logic                  engine_done_i,
  output logic                  irq_o
);

  localparam logic [7:0] PAGE_CTRL   = 8'h00;
  localparam logic [7:0] PAGE_WEIGHT = 8'h57;
  localparam logic [7:0] PAGE_BIAS   = 8'h42;
  localparam logic [7:0] PAGE_IMAGE  = 8'h49;
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t                state;
  logic [7:0]            tmo_cnt;
  logic                  busy, done, irq_en, prot_err, tmo_err;

  logic                  req, page_hit, is_ctrl, is_data, idle_req, ctrl_wr;
  logic                  start_fire, clr, prot_set, done_set, tmo_hit;
  logic                  done_nxt, irq_en_nxt;
  logic [1:0]            data_sel;
  logic [DATA_WIDTH-1:0] rd_data;

  // Byte-select bits above 0 and the word-aligned low address bits carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

  // Address decode, flag set/clear conditions and CSR read mux
  always_comb begin
    req        = wbs_cyc_i & wbs_stb_i;
    page_hit   = (wbs_adr_i[31:16] == BASE_PAGE);
    is_ctrl    = page_hit && (wbs_adr_i[15:8] == PAGE_CTRL);
    is_data    = 1'b0;
    data_sel   = 2'd0;
    if (page_hit) begin
      case (wbs_adr_i[15:8])
        PAGE_WEIGHT: begin is_data = 1'b1; data_sel = 2'd0; end
        PAGE_BIAS:   begin is_data = 1'b1; data_sel = 2'd1; end
        PAGE_IMAGE:  begin is_data = 1'b1; data_sel = 2'd2; end
        default:     begin is_data = 1'b0; data_sel = 2'd0; end
      endcase
    end
    idle_req   = (state == IDLE) && req;
    ctrl_wr    = idle_req && wbs_we_i && is_ctrl && (wbs_adr_i[7:0] == 8'h00) && wbs_sel_i[0];
    start_fire = ctrl_wr && wbs_dat_i[0] && !busy;
    clr        = ctrl_wr && wbs_dat_i[2];
    prot_set   = idle_req && (!(is_ctrl || is_data) || (is_data && wbs_we_i && busy));
    done_set   = engine_done_i && busy;
    tmo_hit    = (state == XFER) && !tgt_ready_i && (tmo_cnt == TMO_LAST);
    // A flag being set in the same cycle as CLR keeps its new value
    done_nxt   = done_set | (done & ~clr);
    irq_en_nxt = ctrl_wr ? wbs_dat_i[1] : irq_en;
    rd_data    = '0;
    if (is_ctrl && (wbs_adr_i[7:0] == 8'h00)) begin
      rd_data[1] = irq_en;
    end else if (is_ctrl && (wbs_adr_i[7:0] == 8'h04)) begin
      rd_data[3:0] = {prot_err, tmo_err, done, busy};
    end
  end

  // Request sequencer FSM with registered bus/target outputs and status flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state          <= IDLE;
      tmo_cnt        <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      irq_en         <= 1'b0;
      prot_err       <= 1'b0;
      tmo_err        <= 1'b0;
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      tgt_valid_o    <= 1'b0;
      tgt_sel_o      <= 2'd0;
      tgt_idx_o      <= 6'd0;
      tgt_data_o     <= '0;
      engine_start_o <= 1'b0;
      irq_o          <= 1'b0;
    end else begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      engine_start_o <= start_fire;
      done           <= done_nxt;
      irq_en         <= irq_en_nxt;
      irq_o          <= done_nxt & irq_en_nxt;
      prot_err       <= prot_set | (prot_err & ~clr);
      tmo_err        <= tmo_hit | (tmo_err & ~clr);
      if (start_fire) begin
        busy <= 1'b1;
      end else if (done_set) begin
        busy <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req) begin
            if (wbs_we_i && is_data && !busy) begin
              state       <= XFER;
              tmo_cnt     <= 8'd0;
              tgt_valid_o <= 1'b1;
              tgt_sel_o   <= data_sel;
              tgt_idx_o   <= wbs_adr_i[7:2];
              tgt_data_o  <= wbs_dat_i;
            end else begin
              state     <= ACK;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= wbs_we_i ? '0 : rd_data;
            end
          end
        end
        XFER: begin
          if (tgt_ready_i || tmo_hit) begin
            tgt_valid_o <= 1'b0;
            // An abandoned cycle gets no acknowledge
            if (wbs_cyc_i) begin
              state     <= ACK;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vt512_wb_ctrl.sv
// tb/tb_vt512_wb_ctrl.sv - scoreboard bench for vt512_wb_ctrl
module tb_vt512_wb_ctrl;

  localparam logic [31:0] A_CTRL   = 32'h414E_0000;
  localparam logic [31:0] A_STATUS = 32'h414E_0004;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [1:0]  sel;
    logic [5:0]  idx;
    logic [31:0] data;
    int          vlen;
    bit          hs;
  } xfer_t;

  logic        clk;
  logic        wb_rst_n;
  logic        wb_stb, wb_cyc, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        tgt_valid_o, tgt_ready;
  logic [1:0]  tgt_sel_o;
  logic [5:0]  tgt_idx_o;
  logic [31:0] tgt_data_o;
  logic        engine_start_o, done_in, irq_o;

  int    errors = 0;
  int    checks = 0;
  int    cyc_cnt = 0;
  int    vrun = 0;
  ack_t  ack_q[$];
  xfer_t xfer_q[$];
  int    start_q[$];

  vt512_wb_ctrl dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (wb_rst_n),
    .wbs_stb_i      (wb_stb),
    .wbs_cyc_i      (wb_cyc),
    .wbs_we_i       (wb_we),
    .wbs_sel_i      (wb_sel),
    .wbs_adr_i      (wb_adr),
    .wbs_dat_i      (wb_dat),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .tgt_valid_o    (tgt_valid_o),
    .tgt_ready_i    (tgt_ready),
    .tgt_sel_o      (tgt_sel_o),
    .tgt_idx_o      (tgt_idx_o),
    .tgt_data_o     (tgt_data_o),
    .engine_start_o (engine_start_o),
    .engine_done_i  (done_in),
    .irq_o          (irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic check_xfer(input bit hs);
    xfer_t e;
    if (xfer_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL xfer_unexpected: sel=%0d idx=%0d data=0x%08h, none expected", tgt_sel_o, tgt_idx_o, tgt_data_o);
    end else begin
      e = xfer_q.pop_front();
      check("xfer_handshake", 32'(hs), 32'(e.hs));
      check("xfer_valid_cycles", vrun, e.vlen);
      check("xfer_sel", 32'(tgt_sel_o), 32'(e.sel));
      check("xfer_idx", 32'(tgt_idx_o), 32'(e.idx));
      check("xfer_data", tgt_data_o, e.data);
    end
  endtask

  // Monitor: sample on the falling edge, pop expectations as the DUT presents outputs
  initial begin
    ack_t a;
    int   s;
    forever begin
      @(negedge clk);
      if (!wb_rst_n) begin
        vrun = 0;
      end else begin
        if (wbs_ack_o) begin
          if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: ack with data 0x%08h, none expected", wbs_dat_o);
          end else begin
            a = ack_q.pop_front();
            check("ack_data", wbs_dat_o, a.data);
            check("ack_cycle", cyc_cnt, a.cyc);
          end
        end else begin
          check("dat_zero_without_ack", wbs_dat_o, 32'h0);
        end
        if (engine_start_o) begin
          if (start_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL start_unexpected: engine_start_o at cycle %0d, none expected", cyc_cnt);
          end else begin
            s = start_q.pop_front();
            check("start_cycle", cyc_cnt, s);
          end
        end
        if (tgt_valid_o) begin
          vrun++;
          if (tgt_ready) begin
            check_xfer(1'b1);
            vrun = 0;
          end
        end else if (vrun != 0) begin
          check_xfer(1'b0);
          vrun = 0;
        end
      end
    end
  end

  task automatic push_xfer(input logic [1:0] sel, input logic [5:0] idx, input logic [31:0] data,
                           input int vlen, input bit hs);
    xfer_t e;
    e.sel = sel; e.idx = idx; e.data = data; e.vlen = vlen; e.hs = hs;
    xfer_q.push_back(e);
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic [31:0] exp_dat, input int exp_lat,
                           input bit exp_start);
    int   waited;
    ack_t a;
    @(posedge clk);
    #2;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = wdat; wb_sel = sel;
    a.data = exp_dat;
    a.cyc  = cyc_cnt + exp_lat;
    ack_q.push_back(a);
    if (exp_start) start_q.push_back(cyc_cnt + 1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!wbs_ack_o && waited < 400);
    if (!wbs_ack_o) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: no ack within %0d cycles for adr 0x%08h", waited, adr);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    wb_rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_sel = 4'h0; wb_adr = 32'h0; wb_dat = 32'h0; tgt_ready = 1'b0; done_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_valid", 32'(tgt_valid_o), 32'h0);
    check("rst_start", 32'(engine_start_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    wb_rst_n = 1'b1;

    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h0, 1, 1'b0);

    // weight write, ready already high: one-cycle valid, ack at N+2
    tgt_ready = 1'b1;
    push_xfer(2'd0, 6'd5, 32'hCAFE_F00D, 1, 1'b1);
    wb_access(1'b1, 32'h414E_5714, 32'hCAFE_F00D, 4'hF, 32'h0, 2, 1'b0);

    // image write, ready held low for 10 cycles of valid
    tgt_ready = 1'b0;
    push_xfer(2'd2, 6'd0, 32'h1234_5678, 11, 1'b1);
    fork
      wb_access(1'b1, 32'h414E_4900, 32'h1234_5678, 4'hF, 32'h0, 12, 1'b0);
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!tgt_valid_o && w < 20);
        repeat (10) @(posedge clk);
        #2;
        tgt_ready = 1'b1;
      end
    join
    tgt_ready = 1'b0;
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h0, 1, 1'b0);

    // bias write, ready never high: timeout after 255 valid cycles
    push_xfer(2'd1, 6'd0, 32'hB1A5_0001, 255, 1'b0);
    wb_access(1'b1, 32'h414E_4200, 32'hB1A5_0001, 4'hF, 32'h0, 256, 1'b0);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h4, 1, 1'b0);

    // CTRL write without byte lane 0 is ignored entirely
    wb_access(1'b1, A_CTRL, 32'h5, 4'hE, 32'h0, 1, 1'b0);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h4, 1, 1'b0);
    wb_access(1'b1, A_CTRL, 32'h4, 4'hF, 32'h0, 1, 1'b0);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h0, 1, 1'b0);

    // start engine with IRQ enabled
    wb_access(1'b1, A_CTRL, 32'h3, 4'hF, 32'h0, 1, 1'b1);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h1, 1, 1'b0);
    wb_access(1'b0, A_CTRL, 32'h0, 4'hF, 32'h2, 1, 1'b0);

    // data write while busy: no transfer, protocol error
    tgt_ready = 1'b1;
    wb_access(1'b1, 32'h414E_4910, 32'h0BAD_0BAD, 4'hF, 32'h0, 1, 1'b0);
    tgt_ready = 1'b0;
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h9, 1, 1'b0);

    // completion
    @(posedge clk);
    #2 done_in = 1'b1;
    @(posedge clk);
    #2 done_in = 1'b0;
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'hA, 1, 1'b0);
    check("irq_after_done", 32'(irq_o), 32'h1);

    // second start, then CLR in the same cycle as its done: DONE survives
    wb_access(1'b1, A_CTRL, 32'h3, 4'hF, 32'h0, 1, 1'b1);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'hB, 1, 1'b0);
    fork
      begin
        @(posedge clk);
        #2 done_in = 1'b1;
        @(posedge clk);
        #2 done_in = 1'b0;
      end
    join_none
    wb_access(1'b1, A_CTRL, 32'h6, 4'hF, 32'h0, 1, 1'b0);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h2, 1, 1'b0);
    check("irq_set_wins", 32'(irq_o), 32'h1);
    wb_access(1'b1, A_CTRL, 32'h6, 4'hF, 32'h0, 1, 1'b0);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h0, 1, 1'b0);
    check("irq_cleared", 32'(irq_o), 32'h0);

    // unmapped read and data-page read
    wb_access(1'b0, 32'h414E_8800, 32'h0, 4'hF, 32'h0, 1, 1'b0);
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h8, 1, 1'b0);
    wb_access(1'b0, 32'h414E_5704, 32'h0, 4'hF, 32'h0, 1, 1'b0);

    // reset in the middle of a transfer
    @(posedge clk);
    #2;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h414E_5708; wb_dat = 32'hDEAD_0001; wb_sel = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    check("valid_before_reset", 32'(tgt_valid_o), 32'h1);
    check("idx_before_reset", 32'(tgt_idx_o), 32'h2);
    wb_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(tgt_valid_o), 32'h0);
    check("async_rst_data", tgt_data_o, 32'h0);
    check("async_rst_idx", 32'(tgt_idx_o), 32'h0);
    check("async_rst_ack", 32'(wbs_ack_o), 32'h0);
    check("async_rst_irq", 32'(irq_o), 32'h0);
    @(posedge clk);
    #2;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk);
    #2 wb_rst_n = 1'b1;
    wb_access(1'b0, A_STATUS, 32'h0, 4'hF, 32'h0, 1, 1'b0);
    wb_access(1'b0, A_CTRL, 32'h0, 4'hF, 32'h0, 1, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("ack_queue_drained", ack_q.size(), 32'h0);
    check("xfer_queue_drained", xfer_q.size(), 32'h0);
    check("start_queue_drained", start_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vt512_wb_ctrl.md
Name: vt512_wb_ctrl

Overview:
Wishbone slave front-end and sequencer for the VT512 accelerator. It decodes the 0x414E_xxxx address pages and owns the control/status registers. Writes to the weight, bias and image pages become a single valid/ready transfer on a shared target bus. It also issues the engine start pulse and raises the completion interrupt.

Parameters:
DATA_WIDTH, 32, width of wbs_dat_* and tgt_data_o.
BASE_PAGE, 16'h414E, required value of wbs_adr_i[31:16].
TIMEOUT, 255, maximum cycles to wait for tgt_ready_i (8-bit counter; must be 1..255).

Ports:
wb_clk_i  in  1  sole clock
wb_rst_n_i  in  1  reset, asynchronous assert, active-low
wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic request
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  single-cycle acknowledge
wbs_dat_o  out  32  read data
tgt_valid_o  out  1  transfer valid to target
tgt_ready_i  in  1  target accepts
tgt_sel_o  out  2  target: 0 weight, 1 bias, 2 image
tgt_idx_o  out  6  word index, wbs_adr_i[7:2]
tgt_data_o  out  32  write data
engine_start_o  out  1  one-cycle start pulse
engine_done_i  in  1  one-cycle completion pulse
irq_o  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous and active-low on wb_rst_n_i.
- Reset state: all outputs 0, FSM in IDLE, all registers 0, timeout counter 0.
- Address decode, on wbs_adr_i[15:8] with [31:16] equal to BASE_PAGE:
  - 0x00: control page. Offset 0x00 is CTRL, offset 0x04 is STATUS.
  - 0x57: weight page. 0x42: bias page. 0x49: image page.
  - Anything else is unmapped.
- CTRL write, applied only when wbs_sel_i[0]=1:
  - bit0 START: self-clearing.
  - bit1 IRQ_EN: stored.
  - bit2 CLR: write-1-to-clear of DONE and all error flags.
- CTRL read returns {30'b0, IRQ_EN, 1'b0}.
- STATUS (read-only) = {28'b0, PROT_ERR, TMO_ERR, DONE, BUSY}.
- FSM states: IDLE, XFER, ACK.
- IDLE: request when cyc&stb=1, sampled at clock edge N.
  - Write to weight/bias/image page with BUSY=0 goes to XFER. In that same edge, latch tgt_sel_o, tgt_idx_o and tgt_data_o, and set tgt_valid_o=1.
  - Every other request goes straight to ACK; wbs_ack_o=1 in cycle N+1. This covers ctrl page, reads of data pages (data 0), unmapped addresses, and data-page writes while BUSY=1.
  - Unmapped access, or data-page write while BUSY=1, sets PROT_ERR with no target transfer.
- XFER:
  - tgt_valid_o held high with stable sel/idx/data until tgt_ready_i=1 is sampled; that is the transfer.
  - Then tgt_valid_o=0 and the FSM goes to ACK.
  - Counter increments each waiting cycle. At TIMEOUT cycles without ready: drop valid, set TMO_ERR, go to ACK.
  - Minimum write latency (ready already high): ack in cycle N+2.
- ACK: wbs_ack_o=1 for exactly one cycle, wbs_dat_o valid in that cycle, then IDLE. wbs_dat_o=0 whenever ack=0.
  - The master drops stb after ack, so IDLE never re-accepts the same request.
- Start: CTRL write with bit0=1 while BUSY=0 asserts engine_start_o for one cycle (the ACK cycle) and sets BUSY. START while BUSY=1 is ignored, with no error.
- Done: engine_done_i while BUSY=1 clears BUSY and sets DONE. engine_done_i while BUSY=0 is ignored.
- irq_o = DONE & IRQ_EN (registered).
- Same-cycle set and CLR of any flag: set wins, flag stays 1.
- Request dropped (cyc=0) while in XFER: finish or time out the transfer, skip ACK, go to IDLE.
- Reset mid-transfer: tgt_valid_o drops immediately (asynchronous); no ack is issued.

Test Plan:
- Write 0xCAFE_F00D to 0x414E_5714 with tgt_ready_i=1 -> tgt_valid_o=1 for 1 cycle with sel=0, idx=5, data=0xCAFE_F00D; ack at N+2.
- Write to 0x414E_4900 with ready held low 10 cycles -> valid stable 11 cycles; transfer occurs; single ack; no TMO_ERR.
- Write to 0x414E_4200 with ready never high -> valid drops after 255 cycles; ack; STATUS read = 0x4.
- Write CTRL=0x3 -> engine_start_o 1-cycle pulse; STATUS=0x1. Write image page while busy -> no tgt_valid_o; STATUS=0x9. Pulse engine_done_i -> STATUS=0xA, irq_o=1.
- Write CTRL=0x6 in the same cycle as a second done condition -> DONE stays 1, irq_o stays 1. Next CTRL=0x6 -> STATUS=0, irq_o=0.
- Read 0x414E_8800 (unmapped) -> ack at N+1 with data 0; PROT_ERR=1. Assert wb_rst_n_i low mid-XFER -> all outputs 0 asynchronously.
